// File: rtl/mire_gen_if.sv
// Wishbone bus bundle between the pattern generator (master) and the SDRAM controller.
// Clock and reset travel with the bus so the master sees them as wshb_ifm.clk / wshb_ifm.rst.
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    input  clk, rst, ack,
    output adr, dat_ms, we, sel, stb, cyc, cti, bte
  );

  modport slave (
    input  clk, rst, adr, dat_ms, we, sel, stb, cyc, cti, bte,
    output ack
  );
endinterface

// File: rtl/mire_gen.sv
// Test-pattern generator: streams HDISP x VDISP pixels into the frame buffer with
// incrementing Wishbone bursts, one idle cycle between bursts, and a pulse per finished frame.
module mire_gen #(
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter int          BURST    = 64,
  parameter logic [31:0] BASE_ADR = 32'h0,
  parameter int          SQ_LOG2  = 4
) (
  wshb_if.master     wshb_ifm,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [23:0] color,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, BURST_ST, GAP} state_t;

  localparam int             BW       = $clog2(BURST);
  localparam logic [BW-1:0]  BEAT_MAX = BW'(BURST - 1);
  localparam logic [15:0]    XMAX     = 16'(HDISP - 1);
  localparam logic [15:0]    YMAX     = 16'(VDISP - 1);
  localparam logic [15:0]    BAR_W    = 16'(HDISP / 8);

  state_t        state, state_d;
  logic [15:0]   x, y;
  logic [BW-1:0] beat;
  logic [31:0]   adr_q;
  logic [1:0]    mode_q;
  logic [23:0]   color_q;
  logic [23:0]   pix;
  logic [2:0]    bar_idx;
  logic          stb, ackd, last_px, last_beat, latch;

  function automatic logic [23:0] bar_color(input logic [2:0] b);
    case (b)
      3'd0:    bar_color = 24'hFFFFFF;
      3'd1:    bar_color = 24'hFFFF00;
      3'd2:    bar_color = 24'h00FFFF;
      3'd3:    bar_color = 24'h00FF00;
      3'd4:    bar_color = 24'hFF00FF;
      3'd5:    bar_color = 24'hFF0000;
      3'd6:    bar_color = 24'h0000FF;
      default: bar_color = 24'h000000;
    endcase
  endfunction

  assign stb       = (state == BURST_ST);
  assign ackd      = stb && wshb_ifm.ack;
  assign last_px   = (x == XMAX) && (y == YMAX);
  assign last_beat = (beat == BEAT_MAX) || last_px;
  // Pattern selection is frozen for a whole frame: only sampled when a burst opens at pixel (0,0).
  assign latch     = (state != BURST_ST) && (state_d == BURST_ST) && (x == 16'd0) && (y == 16'd0);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (enable) state_d = BURST_ST;
      BURST_ST: if (ackd && last_beat) state_d = GAP;
      default:  state_d = enable ? BURST_ST : IDLE;
    endcase
  end

  always_ff @(posedge wshb_ifm.clk or posedge wshb_ifm.rst) begin
    if (wshb_ifm.rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      beat       <= '0;
      adr_q      <= BASE_ADR;
      mode_q     <= '0;
      color_q    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      frame_done <= ackd && last_px;
      if (latch) begin
        mode_q  <= mode;
        color_q <= color;
      end
      if (ackd) begin
        if (last_px) begin
          x     <= '0;
          y     <= '0;
          beat  <= '0;
          adr_q <= BASE_ADR;
        end else begin
          adr_q <= adr_q + 32'd4;
          beat  <= last_beat ? '0 : beat + 1'b1;
          if (x == XMAX) begin
            x <= '0;
            y <= y + 16'd1;
          end else begin
            x <= x + 16'd1;
          end
        end
      end
    end
  end

  assign bar_idx = 3'(x / BAR_W);

  always_comb begin
    pix = color_q;
    case (mode_q)
      2'd0:    pix = color_q;
      2'd1:    pix = bar_color(bar_idx);
      2'd2:    pix = (x[SQ_LOG2] ^ y[SQ_LOG2]) ? color_q : 24'h000000;
      default: pix = {x[7:0], x[7:0], x[7:0]};
    endcase
  end

  assign wshb_ifm.adr    = adr_q;
  assign wshb_ifm.dat_ms = {8'h00, pix};
  assign wshb_ifm.we     = 1'b1;
  assign wshb_ifm.sel    = 4'hF;
  assign wshb_ifm.bte    = 2'b00;
  assign wshb_ifm.stb    = stb;
  assign wshb_ifm.cyc    = stb;
  assign wshb_ifm.cti    = !stb ? 3'b000 : (last_beat ? 3'b111 : 3'b010);

endmodule

// File: tb/tb_mire_gen.sv
// Bench for mire_gen: a full-size instance for burst and pattern checks, a tiny one for frame-level behaviour.
module tb_mire_gen;
  localparam logic [31:0] A_BASE = 32'h0000_1000;
  localparam logic [31:0] B_BASE = 32'h0000_2000;

  logic clk = 1'b0, rst_a = 1'b1, rst_b = 1'b1;
  always #5 clk = ~clk;

  wshb_if wa (.clk(clk), .rst(rst_a));
  wshb_if wb (.clk(clk), .rst(rst_b));

  logic        en_a = 1'b0, en_b = 1'b0, fd_a, fd_b;
  logic [1:0]  mode_a = 2'd0, mode_b = 2'd0;
  logic [23:0] color_a = 24'h0, color_b = 24'h0;
  logic [37:0] bus_a, bus_b;

  mire_gen #(.BASE_ADR(A_BASE)) ua (
    .wshb_ifm(wa), .enable(en_a), .mode(mode_a), .color(color_a), .frame_done(fd_a));
  mire_gen #(.HDISP(8), .VDISP(3), .BURST(16), .BASE_ADR(B_BASE)) ub (
    .wshb_ifm(wb), .enable(en_b), .mode(mode_b), .color(color_b), .frame_done(fd_b));

  assign bus_a = {wa.stb, wa.cyc, wa.cti, fd_a, wa.adr};
  assign bus_b = {wb.stb, wb.cyc, wb.cti, fd_b, wb.adr};

  int compared = 0, mismatched = 0;

  // Reference bus behaviour: ms 0 idle, 1 burst, 2 gap; mn = acked pixels in frame; mbt = beat.
  int ms, mn, mbt;
  bit mfd;

  task automatic model_reset();
    ms = 0; mn = 0; mbt = 0; mfd = 0;
  endtask

  task automatic model_step(input int hd, input int vd, input int bu, input bit en, input bit ak);
    bit last;
    mfd = 0;
    case (ms)
      0: if (en) ms = 1;
      1: if (ak) begin
           last = (mbt == bu - 1) || (mn == hd * vd - 1);
           if (mn == hd * vd - 1) begin
             mn = 0; mbt = 0; mfd = 1;
           end else begin
             mn++;
             mbt = last ? 0 : mbt + 1;
           end
           if (last) ms = 2;
         end
      default: ms = en ? 1 : 0;
    endcase
  endtask

  function automatic logic [37:0] exp_bus(input int hd, input int vd, input int bu, input logic [31:0] base);
    logic es;
    logic [2:0] ec;
    es = (ms == 1);
    ec = !es ? 3'b000 : (((mbt == bu - 1) || (mn == hd * vd - 1)) ? 3'b111 : 3'b010);
    return {es, es, ec, mfd, base + 32'(4 * mn)};
  endfunction

  task automatic start_a(input logic [1:0] m, input logic [23:0] col);
    @(negedge clk); rst_a = 1'b1;
    @(negedge clk); rst_a = 1'b0;
    mode_a = m; color_a = col; en_a = 1'b1; wa.ack = 1'b1;
    model_reset(); model_step(800, 480, 64, 1'b1, 1'b1);
  endtask

  task automatic start_b(input logic [1:0] m, input logic [23:0] col);
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk); rst_b = 1'b0;
    mode_b = m; color_b = col; en_b = 1'b1; wb.ack = 1'b1;
    model_reset(); model_step(8, 3, 16, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; wa.ack = 1'b0; wb.ack = 1'b0; en_a = 1'b0; en_b = 1'b0;
    @(negedge clk);
    compared++;
    if (bus_a !== {6'b0, A_BASE}) begin
      mismatched++; $display("FAIL reset_a got %h want %h", bus_a, {6'b0, A_BASE});
    end
    compared++;
    if (bus_b !== {6'b0, B_BASE}) begin
      mismatched++; $display("FAIL reset_b got %h want %h", bus_b, {6'b0, B_BASE});
    end
    compared++;
    if ({wa.we, wa.sel, wa.bte} !== 7'b1_1111_00) begin
      mismatched++; $display("FAIL const_out got %b want 1111100", {wa.we, wa.sel, wa.bte});
    end
    rst_a = 1'b0; rst_b = 1'b0; wa.ack = 1'b1; wb.ack = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if ({wa.stb, wb.stb, wa.adr} !== {2'b00, A_BASE}) begin
      mismatched++; $display("FAIL idle_hold got %h want %h", {wa.stb, wb.stb, wa.adr}, {2'b00, A_BASE});
    end
  endtask

  task automatic test_first_bursts();
    int n7 = 0;
    start_a(2'd0, 24'h00FF00);
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      compared++;
      if (bus_a !== exp_bus(800, 480, 64, A_BASE)) begin
        mismatched++; $display("FAIL burst_bus c=%0d got %h want %h", c, bus_a, exp_bus(800, 480, 64, A_BASE));
      end
      if (wa.stb) begin
        compared++;
        if (wa.dat_ms !== 32'h0000FF00) begin
          mismatched++; $display("FAIL solid_dat c=%0d got %h want 0000ff00", c, wa.dat_ms);
        end
        if (wa.cti == 3'b111) n7++;
      end
      if (c == 0) begin
        compared++;
        if ({wa.stb, wa.adr} !== {1'b1, A_BASE}) begin
          mismatched++; $display("FAIL first_beat got %h want %h", {wa.stb, wa.adr}, {1'b1, A_BASE});
        end
      end
      if (c == 64) begin
        compared++;
        if (wa.stb !== 1'b0) begin
          mismatched++; $display("FAIL gap_cycle got %b want 0", wa.stb);
        end
      end
      if (c == 65) begin
        compared++;
        if ({wa.stb, wa.adr} !== {1'b1, A_BASE + 32'd256}) begin
          mismatched++; $display("FAIL second_burst got %h want %h", {wa.stb, wa.adr}, {1'b1, A_BASE + 32'd256});
        end
      end
      model_step(800, 480, 64, 1'b1, 1'b1);
    end
    compared++;
    if (n7 != 2) begin
      mismatched++; $display("FAIL cti_last_count got %0d want 2", n7);
    end
  endtask

  task automatic test_bars();
    int hits = 0;
    logic [23:0] want;
    bit chk;
    start_a(2'd1, 24'h0);
    for (int c = 0; c < 900 && mn < 800; c++) begin
      @(negedge clk);
      compared++;
      if (bus_a !== exp_bus(800, 480, 64, A_BASE)) begin
        mismatched++; $display("FAIL bars_bus c=%0d got %h want %h", c, bus_a, exp_bus(800, 480, 64, A_BASE));
      end
      chk = 1'b1; want = 24'h0;
      case (mn)
        0, 99:   want = 24'hFFFFFF;
        100:     want = 24'hFFFF00;
        250:     want = 24'h00FFFF;
        450:     want = 24'hFF00FF;
        799:     want = 24'h000000;
        default: chk = 1'b0;
      endcase
      if (chk && ms == 1) begin
        hits++; compared++;
        if (wa.dat_ms !== {8'h0, want}) begin
          mismatched++; $display("FAIL bars x=%0d got %h want %h", mn, wa.dat_ms, {8'h0, want});
        end
      end
      model_step(800, 480, 64, 1'b1, 1'b1);
    end
    compared++;
    if (hits != 6) begin
      mismatched++; $display("FAIL bars_hits got %0d want 6", hits);
    end
  endtask

  task automatic test_checker();
    int hits = 0;
    logic [23:0] want;
    bit chk;
    start_a(2'd2, 24'h123456);
    for (int c = 0; c < 14000 && mn <= 12816; c++) begin
      @(negedge clk);
      compared++;
      if (bus_a !== exp_bus(800, 480, 64, A_BASE)) begin
        mismatched++; $display("FAIL chk_bus c=%0d got %h want %h", c, bus_a, exp_bus(800, 480, 64, A_BASE));
      end
      chk = 1'b1; want = 24'h0;
      case (mn)
        0, 15:   want = 24'h000000;
        16:      want = 24'h123456;
        12800:   want = 24'h123456;
        12816:   want = 24'h000000;
        default: chk = 1'b0;
      endcase
      if (chk && ms == 1) begin
        hits++; compared++;
        if (wa.dat_ms !== {8'h0, want}) begin
          mismatched++; $display("FAIL checker n=%0d got %h want %h", mn, wa.dat_ms, {8'h0, want});
        end
      end
      model_step(800, 480, 64, 1'b1, 1'b1);
    end
    compared++;
    if (hits != 5) begin
      mismatched++; $display("FAIL checker_hits got %0d want 5", hits);
    end
  endtask

  task automatic test_gradient();
    int hits = 0;
    logic [23:0] want;
    bit chk;
    start_a(2'd3, 24'hABCDEF);
    for (int c = 0; c < 400 && mn <= 300; c++) begin
      @(negedge clk);
      chk = 1'b1; want = 24'h0;
      case (mn)
        0:       want = 24'h000000;
        255:     want = 24'hFFFFFF;
        256:     want = 24'h000000;
        300:     want = 24'h2C2C2C;
        default: chk = 1'b0;
      endcase
      if (chk && ms == 1) begin
        hits++; compared++;
        if ({wa.stb, wa.dat_ms} !== {1'b1, 8'h0, want}) begin
          mismatched++; $display("FAIL gradient x=%0d got %h want %h", mn, wa.dat_ms, {8'h0, want});
        end
      end
      model_step(800, 480, 64, 1'b1, 1'b1);
    end
    compared++;
    if (hits != 4) begin
      mismatched++; $display("FAIL gradient_hits got %0d want 4", hits);
    end
  endtask

  task automatic test_short_frame();
    int fd_cycle = -1, nfd = 0;
    start_b(2'd0, 24'h00FF00);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      compared++;
      if (bus_b !== exp_bus(8, 3, 16, B_BASE)) begin
        mismatched++; $display("FAIL short_bus c=%0d got %h want %h", c, bus_b, exp_bus(8, 3, 16, B_BASE));
      end
      if (fd_b) begin nfd++; fd_cycle = c; end
      if (c == 16 || c == 26) begin
        compared++;
        if ({wb.stb, wb.adr} !== ((c == 16) ? {1'b0, B_BASE + 32'd64} : {1'b1, B_BASE})) begin
          mismatched++; $display("FAIL short_edge c=%0d got %h", c, {wb.stb, wb.adr});
        end
      end
      if (c == 24) begin
        compared++;
        if (wb.cti !== 3'b111) begin
          mismatched++; $display("FAIL short_cti got %b want 111", wb.cti);
        end
      end
      model_step(8, 3, 16, 1'b1, 1'b1);
    end
    compared++;
    if (nfd != 1 || fd_cycle != 25) begin
      mismatched++; $display("FAIL frame_done got %0d pulses at %0d want 1 at 25", nfd, fd_cycle);
    end
  endtask

  task automatic test_mode_change();
    int fr = 0;
    logic [7:0] xv;
    start_b(2'd0, 24'h00FF00);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      compared++;
      if (bus_b !== exp_bus(8, 3, 16, B_BASE)) begin
        mismatched++; $display("FAIL mchg_bus c=%0d got %h want %h", c, bus_b, exp_bus(8, 3, 16, B_BASE));
      end
      if (ms == 1) begin
        xv = 8'(mn % 8);
        compared++;
        if (wb.dat_ms !== ((fr == 0) ? 32'h0000FF00 : {8'h0, xv, xv, xv})) begin
          mismatched++; $display("FAIL mchg_dat fr=%0d n=%0d got %h", fr, mn, wb.dat_ms);
        end
      end
      if (c == 5) begin mode_b = 2'd3; color_b = 24'hFFFFFF; end
      model_step(8, 3, 16, 1'b1, 1'b1);
      if (mfd) fr++;
    end
    compared++;
    if (fr != 2) begin
      mismatched++; $display("FAIL mchg_frames got %0d want 2", fr);
    end
  endtask

  task automatic test_enable_drop();
    bit en;
    start_b(2'd0, 24'h00FF00);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      compared++;
      if (bus_b !== exp_bus(8, 3, 16, B_BASE)) begin
        mismatched++; $display("FAIL endrop_bus c=%0d got %h want %h", c, bus_b, exp_bus(8, 3, 16, B_BASE));
      end
      if (c == 25) begin
        compared++;
        if ({wb.stb, wb.adr} !== {1'b0, B_BASE + 32'd64}) begin
          mismatched++; $display("FAIL endrop_hold got %h want %h", {wb.stb, wb.adr}, {1'b0, B_BASE + 32'd64});
        end
      end
      if (c == 31) begin
        compared++;
        if ({wb.stb, wb.adr, wb.dat_ms} !== {1'b1, B_BASE + 32'd64, 32'h0000FF00}) begin
          mismatched++; $display("FAIL endrop_resume got %h", {wb.stb, wb.adr, wb.dat_ms});
        end
      end
      en = (c < 5) || (c >= 30);
      en_b = en;
      model_step(8, 3, 16, en, 1'b1);
    end
  endtask

  task automatic test_reset_midburst();
    start_b(2'd0, 24'h00FF00);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      model_step(8, 3, 16, 1'b1, 1'b1);
    end
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    compared++;
    if ({wb.stb, wb.cyc, wb.adr} !== {2'b00, B_BASE}) begin
      mismatched++; $display("FAIL rst_mid got %h want %h", {wb.stb, wb.cyc, wb.adr}, {2'b00, B_BASE});
    end
    @(negedge clk);
    rst_b = 1'b0;
    model_reset(); model_step(8, 3, 16, 1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      compared++;
      if (bus_b !== exp_bus(8, 3, 16, B_BASE)) begin
        mismatched++; $display("FAIL rst_restart c=%0d got %h want %h", c, bus_b, exp_bus(8, 3, 16, B_BASE));
      end
      model_step(8, 3, 16, 1'b1, 1'b1);
    end
  endtask

  task automatic test_stall_frame();
    int acks = 0;
    bit ak, seen = 0, prev_stall = 0;
    logic [31:0] prev_adr = 32'h0, prev_dat = 32'h0;
    logic [7:0] xv;
    start_b(2'd3, 24'h0);
    wb.ack = 1'b0;
    model_reset(); model_step(8, 3, 16, 1'b1, 1'b0);
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      compared++;
      if (bus_b !== exp_bus(8, 3, 16, B_BASE)) begin
        mismatched++; $display("FAIL stall_bus c=%0d got %h want %h", c, bus_b, exp_bus(8, 3, 16, B_BASE));
      end
      if (ms == 1) begin
        xv = 8'(mn % 8);
        compared++;
        if (wb.dat_ms !== {8'h0, xv, xv, xv}) begin
          mismatched++; $display("FAIL stall_dat n=%0d got %h", mn, wb.dat_ms);
        end
      end
      if (prev_stall) begin
        compared++;
        if ({wb.adr, wb.dat_ms} !== {prev_adr, prev_dat}) begin
          mismatched++; $display("FAIL stall_stable got %h want %h", {wb.adr, wb.dat_ms}, {prev_adr, prev_dat});
        end
      end
      if (fd_b) begin
        seen = 1;
        compared++;
        if (acks != 24) begin
          mismatched++; $display("FAIL frame_acks got %0d want 24", acks);
        end
      end
      ak = 1'($urandom_range(0, 1));
      wb.ack = ak;
      if (wb.stb && ak) acks++;
      prev_stall = wb.stb && !ak;
      prev_adr = wb.adr;
      prev_dat = wb.dat_ms;
      model_step(8, 3, 16, 1'b1, ak);
    end
    if (!seen) begin
      compared++; mismatched++;
      $display("FAIL stall_timeout got no frame_done want pulse within 400 cycles");
    end
  endtask

  initial begin
    test_reset();
    test_first_bursts();
    test_bars();
    test_checker();
    test_gradient();
    test_short_frame();
    test_mode_change();
    test_enable_drop();
    test_reset_midburst();
    test_stall_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
